bcd_press_counter: RTL and testbench

//  Counts debounced push-button events in BCD for display.

---
 rtl/bcd_press_counter.sv | 99 +++++++++
 tb/tb_bcd_press_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_press_counter.sv
// Debounced push-button event counter with an NDIGITS-digit BCD output.
// Define SATURATE_EN to make the count saturate at its limits instead of wrapping.
module bcd_press_counter #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   clear,
    output logic [4*NDIGITS-1:0]   bcd_count,
    output logic                   ovf,
    output logic                   unf
);

    logic                 inc_q;
    logic                 dec_q;
    logic                 inc_e;
    logic                 dec_e;
    logic [4*NDIGITS-1:0] inc_next;
    logic [4*NDIGITS-1:0] dec_next;
    logic                 all_nine;
    logic                 all_zero;
    logic                 carry;
    logic                 borrow;
    logic [3:0]           d_inc;
    logic [3:0]           d_dec;

    assign inc_e = inc & ~inc_q;
    assign dec_e = dec & ~dec_q;

    // Ripple carry/borrow across all digits in one cycle; illegal digits become 0.
    always_comb begin
        inc_next = '0;
        dec_next = '0;
        carry    = 1'b1;
        borrow   = 1'b1;
        d_inc    = 4'd0;
        d_dec    = 4'd0;
        for (int k = 0; k < NDIGITS; k++) begin
            d_inc = bcd_count[4*k +: 4];
            if (d_inc > 4'd9)
                inc_next[4*k +: 4] = 4'd0;
            else if (carry)
                inc_next[4*k +: 4] = (d_inc == 4'd9) ? 4'd0 : d_inc + 4'd1;
            else
                inc_next[4*k +: 4] = d_inc;
            carry = carry & (d_inc == 4'd9);

            d_dec = bcd_count[4*k +: 4];
            if (d_dec > 4'd9)
                dec_next[4*k +: 4] = 4'd0;
            else if (borrow)
                dec_next[4*k +: 4] = (d_dec == 4'd0) ? 4'd9 : d_dec - 4'd1;
            else
                dec_next[4*k +: 4] = d_dec;
            borrow = borrow & (d_dec == 4'd0);
        end
        all_nine = carry;
        all_zero = borrow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_count <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
        end else begin
            inc_q <= inc;
            dec_q <= dec;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            if (clear) begin
                bcd_count <= '0;
            end else if (inc_e && dec_e) begin
                bcd_count <= bcd_count;
            end else if (inc_e) begin
                ovf <= all_nine;
`ifdef SATURATE_EN
                if (!all_nine)
                    bcd_count <= inc_next;
`else
                bcd_count <= inc_next;
`endif
            end else if (dec_e) begin
                unf <= all_zero;
`ifdef SATURATE_EN
                if (!all_zero)
                    bcd_count <= dec_next;
`else
                bcd_count <= dec_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bcd_press_counter.sv
// Self-checking bench for bcd_press_counter: directed scenarios followed by
// random inc/dec/clear traffic compared against an integer reference model.
module tb_bcd_press_counter;

    localparam int NDIGITS = 4;
    localparam int W       = 4*NDIGITS;

    logic         clk;
    logic         rst;
    logic         inc;
    logic         dec;
    logic         clear;
    logic [W-1:0] bcd_count;
    logic         ovf;
    logic         unf;

    int maxVal;
    int modelCount;
    int modelOvf;
    int modelUnf;
    int prevInc;
    int prevDec;
    int assertCount;
    int failCount;

    bcd_press_counter #(.NDIGITS(NDIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc),
        .dec       (dec),
        .clear     (clear),
        .bcd_count (bcd_count),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] toBcd(input int n);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = n;
        for (int k = 0; k < NDIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic modelReset();
        modelCount = 0;
        modelOvf   = 0;
        modelUnf   = 0;
        prevInc    = 0;
        prevDec    = 0;
    endtask

    // Reference behaviour: plain integer count with wrap/saturate at 0 and 10^N-1.
    task automatic modelUpdate(input int i, input int d, input int c);
        int incE;
        int decE;
        incE = (i != 0 && prevInc == 0) ? 1 : 0;
        decE = (d != 0 && prevDec == 0) ? 1 : 0;
        prevInc  = i;
        prevDec  = d;
        modelOvf = 0;
        modelUnf = 0;
        if (c != 0) begin
            modelCount = 0;
        end else if (incE != 0 && decE != 0) begin
        end else if (incE != 0) begin
            if (modelCount == maxVal) begin
                modelOvf = 1;
`ifndef SATURATE_EN
                modelCount = 0;
`endif
            end else begin
                modelCount = modelCount + 1;
            end
        end else if (decE != 0) begin
            if (modelCount == 0) begin
                modelUnf = 1;
`ifndef SATURATE_EN
                modelCount = maxVal;
`endif
            end else begin
                modelCount = modelCount - 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [W-1:0] expCount;
        logic         expOvf;
        logic         expUnf;
        expCount = toBcd(modelCount);
        expOvf   = (modelOvf != 0);
        expUnf   = (modelUnf != 0);
        assertCount++;
        assert (bcd_count === expCount) else begin
            failCount++;
            $error("[TB] FAIL %s count: got %h expected %h", tag, bcd_count, expCount);
        end
        assertCount++;
        assert (ovf === expOvf) else begin
            failCount++;
            $error("[TB] FAIL %s ovf: got %b expected %b", tag, ovf, expOvf);
        end
        assertCount++;
        assert (unf === expUnf) else begin
            failCount++;
            $error("[TB] FAIL %s unf: got %b expected %b", tag, unf, expUnf);
        end
    endtask

    // Inputs change on the falling edge; results are checked on the next falling edge.
    task automatic applyStimulus(input logic i, input logic d, input logic c, input string tag);
        inc   = i;
        dec   = d;
        clear = c;
        @(posedge clk);
        modelUpdate(int'(i), int'(d), int'(c));
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic pulseInc(input int n, input string tag);
        for (int p = 0; p < n; p++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, tag);
            applyStimulus(1'b0, 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        maxVal      = 1;
        for (int k = 0; k < NDIGITS; k++) maxVal = maxVal * 10;
        maxVal      = maxVal - 1;
        assertCount = 0;
        failCount   = 0;
        modelReset();

        // Reset with both requests already high; both edges land on the first clock.
        rst   = 1'b1;
        inc   = 1'b1;
        dec   = 1'b1;
        clear = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, "both_after_reset");
        applyStimulus(1'b0, 1'b0, 1'b0, "both_release");

        pulseInc(12, "pulse12");
        for (int h = 0; h < 20; h++) applyStimulus(1'b1, 1'b0, 1'b0, "held_inc");
        applyStimulus(1'b0, 1'b0, 1'b0, "held_release");

        applyStimulus(1'b0, 1'b0, 1'b1, "clear");
        applyStimulus(1'b0, 1'b0, 1'b0, "idle");
        applyStimulus(1'b0, 1'b1, 1'b0, "dec_underflow");
        applyStimulus(1'b0, 1'b0, 1'b0, "unf_clears");
        applyStimulus(1'b1, 1'b0, 1'b0, "inc_from_max");
        applyStimulus(1'b0, 1'b0, 1'b0, "ovf_clears");

        applyStimulus(1'b0, 1'b0, 1'b1, "clear2");
        pulseInc(1000, "load1000");
        applyStimulus(1'b0, 1'b1, 1'b0, "dec_1000");
        applyStimulus(1'b0, 1'b0, 1'b0, "dec_release");
        applyStimulus(1'b1, 1'b0, 1'b0, "inc_0999");
        applyStimulus(1'b0, 1'b0, 1'b0, "inc_release");

        applyStimulus(1'b0, 1'b0, 1'b1, "clear3");
        pulseInc(42, "load42");
        applyStimulus(1'b1, 1'b0, 1'b1, "clear_with_inc");
        applyStimulus(1'b1, 1'b0, 1'b0, "inc_consumed");
        applyStimulus(1'b0, 1'b0, 1'b0, "inc_drop");

        pulseInc(500, "load500");
        #2 rst = 1'b1;
        modelReset();
        #1 checkOutput("async_reset");
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_release");

        // Random traffic with occasional clears, biased to wander across both wrap points.
        for (int r = 0; r < 3000; r++) begin
            logic ri;
            logic rd;
            logic rc;
            ri = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 2) == 0);
            rc = ($urandom_range(0, 31) == 0);
            applyStimulus(ri, rd, rc, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
